sfp_link_ctrl: RTL and testbench

Link-level controller that sequences the SFP optical module and gates the serial transmitter and receiver. It handles the power-up hold of TX_DISABLE, the module init window and LOS debounce. It also tracks link liveness from receiver frame strobes and runs bounded TX-fault recovery by pulsing TX_DISABLE. It sits between the SFP pins and the serial_tx_master / serial_rx instances in the top level, and drives SFP_TX_DIS_N in place of the transmitter.

---
 rtl/sfp_link_ctrl_pkg.sv | 60 ++++++
 rtl/sfp_sig_filter.sv | 66 ++++++
 rtl/sfp_link_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_sfp_link_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sfp_link_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sfp_link_ctrl_pkg
// Shared definitions for the SFP link controller and any LED/debug logic that
// decodes o_state: state codes, default timing constants, the Moore output
// bundle and its decode function.
// -----------------------------------------------------------------------------
package sfp_link_ctrl_pkg;

    // Default timing at 40 MHz
    localparam int DEF_TINIT_CYC   = 12000000;  // 300 ms module init window
    localparam int DEF_TDIS_CYC    = 400;       // 10 us TX_DISABLE pulse
    localparam int DEF_LOS_DEB_CYC = 4000;      // 100 us LOS debounce
    localparam int DEF_RX_TO_CYC   = 400000;    // 10 ms receive timeout
    localparam int DEF_MAX_RETRY   = 3;

    // State codes are visible on o_state, so their values are fixed
    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_INIT      = 3'd1,
        ST_WAIT_LINK = 3'd2,
        ST_LINK_UP   = 3'd3,
        ST_FLT_DIS   = 3'd4,
        ST_LOCKOUT   = 3'd5
    } link_state_e;

    typedef struct packed {
        logic tx_dis_n;
        logic tx_en;
        logic rx_en;
        logic link_up;
        logic fault;
        logic lockout;
    } link_out_t;

    // Moore output decode; unused codes fall back to the safe all-off pattern
    function automatic link_out_t decode_outputs(input link_state_e st);
        link_out_t o;
        o = '{default: 1'b0};
        case (st)
            ST_OFF:       o = '{default: 1'b0};
            ST_INIT:      o.tx_dis_n = 1'b1;
            ST_WAIT_LINK: begin o.tx_dis_n = 1'b1; o.tx_en = 1'b1; end
            ST_LINK_UP:   begin
                o.tx_dis_n = 1'b1; o.tx_en = 1'b1;
                o.rx_en    = 1'b1; o.link_up = 1'b1;
            end
            ST_FLT_DIS:   o.fault = 1'b1;
            ST_LOCKOUT:   begin o.fault = 1'b1; o.lockout = 1'b1; end
            default:      o = '{default: 1'b0};
        endcase
        return o;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sfp_sig_filter.sv
// -----------------------------------------------------------------------------
// sfp_sig_filter
// 2-FF synchronizer for an asynchronous SFP status pin, optionally followed by
// a debouncer that changes its output only after DEB_CYC consecutive
// synchronized cycles at the new level. DEB_CYC = 0 gives sync only.
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous active-high reset
//   raw  in  asynchronous pin level
//   filt out synchronized (and debounced) level; RST_VAL while in reset
//            when debounced, 0 when sync only
// -----------------------------------------------------------------------------
module sfp_sig_filter #(
    parameter int   DEB_CYC = 0,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt
);

    logic meta_r;
    logic sync_r;

    // Two-stage synchronizer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= raw;
            sync_r <= meta_r;
        end
    end

    generate
        if (DEB_CYC == 0) begin : g_sync_only
            assign filt = sync_r;
        end else begin : g_debounce
            localparam int            CW       = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
            localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

            logic [CW-1:0] cnt_r;
            logic          deb_r;

            // Count consecutive disagreeing cycles; any agreement restarts the count
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_r <= {CW{1'b0}};
                    deb_r <= RST_VAL;
                end else if (sync_r == deb_r) begin
                    cnt_r <= {CW{1'b0}};
                end else if (cnt_r == CNT_LAST) begin
                    cnt_r <= {CW{1'b0}};
                    deb_r <= sync_r;
                end else begin
                    cnt_r <= cnt_r + CW'(1);
                end
            end

            assign filt = deb_r;
        end
    endgenerate

endmodule

// File: rtl/sfp_link_ctrl.sv
// -----------------------------------------------------------------------------
// sfp_link_ctrl
// Sequences the SFP module (power-up TX_DISABLE hold, init window, LOS
// debounce), tracks link liveness from receiver frame strobes and runs
// bounded TX-fault recovery by pulsing TX_DISABLE.
// Ports:
//   i_clk, i_res          clock, asynchronous active-high reset
//   i_enable              link enable
//   i_sfp_los             raw SFP_LOSS_SIG (async)
//   i_sfp_tx_flt          raw SFP_TX_FLT (async)
//   i_rx_frame_ok         one-cycle strobe per valid received frame
//   i_retry_clr           one-cycle strobe, leaves LOCKOUT
//   o_sfp_tx_dis_n        SFP TX disable pin (0 = disabled)
//   o_tx_en, o_rx_en      transmitter enable, receiver output gate
//   o_link_up             link alive
//   o_fault, o_lockout    fault recovery / lockout indication
//   o_state               current state code
//   o_retry_cnt           faults consumed since last link-up
// -----------------------------------------------------------------------------
module sfp_link_ctrl
    import sfp_link_ctrl_pkg::*;
#(
    parameter int TINIT_CYC   = DEF_TINIT_CYC,
    parameter int TDIS_CYC    = DEF_TDIS_CYC,
    parameter int LOS_DEB_CYC = DEF_LOS_DEB_CYC,
    parameter int RX_TO_CYC   = DEF_RX_TO_CYC,
    parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
    input  logic       i_clk,
    input  logic       i_res,
    input  logic       i_enable,
    input  logic       i_sfp_los,
    input  logic       i_sfp_tx_flt,
    input  logic       i_rx_frame_ok,
    input  logic       i_retry_clr,
    output logic       o_sfp_tx_dis_n,
    output logic       o_tx_en,
    output logic       o_rx_en,
    output logic       o_link_up,
    output logic       o_fault,
    output logic       o_lockout,
    output logic [2:0] o_state,
    output logic [1:0] o_retry_cnt
);

    localparam int            TMAX      = max3(TINIT_CYC, TDIS_CYC, RX_TO_CYC);
    localparam int            TW        = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] TINIT_LD  = TW'(TINIT_CYC - 1);
    localparam logic [TW-1:0] TDIS_LD   = TW'(TDIS_CYC - 1);
    localparam logic [TW-1:0] RX_TO_LD  = TW'(RX_TO_CYC - 1);
    localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);

    logic          los_deb_s;
    logic          flt_s;
    link_state_e   state_r, state_nxt_s;
    logic [TW-1:0] timer_r, timer_nxt_s;
    logic [1:0]    retry_r, retry_nxt_s;
    logic          expire_s;
    logic          go_fault_s;
    link_out_t     out_r;

    sfp_sig_filter #(.DEB_CYC(LOS_DEB_CYC), .RST_VAL(1'b1)) u_los_filter (
        .clk  (i_clk),
        .rst  (i_res),
        .raw  (i_sfp_los),
        .filt (los_deb_s)
    );

    sfp_sig_filter #(.DEB_CYC(0), .RST_VAL(1'b0)) u_flt_filter (
        .clk  (i_clk),
        .rst  (i_res),
        .raw  (i_sfp_tx_flt),
        .filt (flt_s)
    );

    assign expire_s = (timer_r == {TW{1'b0}});

    // Next-state, timer and retry-count logic
    always_comb begin
        state_nxt_s = state_r;
        timer_nxt_s = expire_s ? {TW{1'b0}} : (timer_r - TW'(1));
        retry_nxt_s = retry_r;
        go_fault_s  = 1'b0;

        case (state_r)
            ST_OFF: begin
                if (i_enable) begin
                    state_nxt_s = ST_INIT;
                    timer_nxt_s = TINIT_LD;
                end else begin
                    timer_nxt_s = {TW{1'b0}};
                end
            end
            ST_INIT: begin
                // Fault is ignored until the init window ends
                if (!i_enable) begin
                    state_nxt_s = ST_OFF;
                end else if (expire_s && flt_s) begin
                    go_fault_s = 1'b1;
                end else if (expire_s) begin
                    state_nxt_s = ST_WAIT_LINK;
                    timer_nxt_s = RX_TO_LD;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_WAIT_LINK: begin
                // Timeout here only restarts the wait: a missing peer is not an error
                if (!i_enable) begin
                    state_nxt_s = ST_OFF;
                end else if (flt_s) begin
                    go_fault_s = 1'b1;
                end else if (expire_s) begin
                    timer_nxt_s = RX_TO_LD;
                end else if (i_rx_frame_ok && !los_deb_s) begin
                    state_nxt_s = ST_LINK_UP;
                    timer_nxt_s = RX_TO_LD;
                    retry_nxt_s = 2'd0;
                end else begin
                    state_nxt_s = ST_WAIT_LINK;
                end
            end
            ST_LINK_UP: begin
                if (!i_enable) begin
                    state_nxt_s = ST_OFF;
                end else if (flt_s) begin
                    go_fault_s = 1'b1;
                end else if (los_deb_s || expire_s) begin
                    state_nxt_s = ST_WAIT_LINK;
                    timer_nxt_s = RX_TO_LD;
                end else if (i_rx_frame_ok) begin
                    timer_nxt_s = RX_TO_LD;
                end else begin
                    state_nxt_s = ST_LINK_UP;
                end
            end
            ST_FLT_DIS: begin
                if (!i_enable) begin
                    state_nxt_s = ST_OFF;
                end else if (expire_s) begin
                    state_nxt_s = ST_INIT;
                    timer_nxt_s = TINIT_LD;
                end else begin
                    state_nxt_s = ST_FLT_DIS;
                end
            end
            ST_LOCKOUT: begin
                if (i_retry_clr) begin
                    state_nxt_s = ST_OFF;
                    retry_nxt_s = 2'd0;
                end else begin
                    state_nxt_s = ST_LOCKOUT;
                end
            end
            default: begin
                state_nxt_s = ST_OFF;
                timer_nxt_s = {TW{1'b0}};
            end
        endcase

        // Fault entry: lockout once the retry budget is spent, else pulse TX_DISABLE
        if (go_fault_s) begin
            if (retry_r >= RETRY_MAX) begin
                state_nxt_s = ST_LOCKOUT;
            end else begin
                state_nxt_s = ST_FLT_DIS;
                retry_nxt_s = retry_r + 2'd1;
                timer_nxt_s = TDIS_LD;
            end
        end else begin
            retry_nxt_s = retry_nxt_s;
        end
    end

    // State, timer, retry count and Moore outputs (decoded from next state so
    // the outputs change on the same edge as the state)
    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            state_r <= ST_OFF;
            timer_r <= {TW{1'b0}};
            retry_r <= 2'd0;
            out_r   <= '{default: 1'b0};
        end else begin
            state_r <= state_nxt_s;
            timer_r <= timer_nxt_s;
            retry_r <= retry_nxt_s;
            out_r   <= decode_outputs(state_nxt_s);
        end
    end

    assign o_sfp_tx_dis_n = out_r.tx_dis_n;
    assign o_tx_en        = out_r.tx_en;
    assign o_rx_en        = out_r.rx_en;
    assign o_link_up      = out_r.link_up;
    assign o_fault        = out_r.fault;
    assign o_lockout      = out_r.lockout;
    assign o_state        = state_r;
    assign o_retry_cnt    = retry_r;

endmodule

// File: tb/tb_sfp_link_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sfp_link_ctrl
// Directed bench for sfp_link_ctrl with shortened timing. Expected output
// vectors are queued as stimulus is applied and compared when the DUT is
// sampled, 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_sfp_link_ctrl;

    logic       clk = 1'b0;
    logic       res;
    logic       enable;
    logic       sfp_los;
    logic       sfp_tx_flt;
    logic       rx_frame_ok;
    logic       retry_clr;
    logic       sfp_tx_dis_n;
    logic       tx_en;
    logic       rx_en;
    logic       link_up;
    logic       fault;
    logic       lockout;
    logic [2:0] state;
    logic [1:0] retry_cnt;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [10:0] v;
    } sb_entry_t;

    sb_entry_t sb[$];

    logic [10:0] obs;
    assign obs = {sfp_tx_dis_n, tx_en, rx_en, link_up, fault, lockout, state, retry_cnt};

    sfp_link_ctrl #(
        .TINIT_CYC   (20),
        .TDIS_CYC    (4),
        .LOS_DEB_CYC (3),
        .RX_TO_CYC   (50),
        .MAX_RETRY   (2)
    ) dut (
        .i_clk          (clk),
        .i_res          (res),
        .i_enable       (enable),
        .i_sfp_los      (sfp_los),
        .i_sfp_tx_flt   (sfp_tx_flt),
        .i_rx_frame_ok  (rx_frame_ok),
        .i_retry_clr    (retry_clr),
        .o_sfp_tx_dis_n (sfp_tx_dis_n),
        .o_tx_en        (tx_en),
        .o_rx_en        (rx_en),
        .o_link_up      (link_up),
        .o_fault        (fault),
        .o_lockout      (lockout),
        .o_state        (state),
        .o_retry_cnt    (retry_cnt)
    );

    always #5 clk = ~clk;

    // Expected vector {dis_n, tx_en, rx_en, link_up, fault, lockout, state, retry}
    function automatic logic [10:0] ev(input logic [2:0] st, input logic [1:0] rc);
        logic [5:0] o;
        case (st)
            3'd0:    o = 6'b000000;
            3'd1:    o = 6'b100000;
            3'd2:    o = 6'b110000;
            3'd3:    o = 6'b111100;
            3'd4:    o = 6'b000010;
            3'd5:    o = 6'b000011;
            default: o = 6'b000000;
        endcase
        return {o, st, rc};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [2:0] st, input logic [1:0] rc);
        sb_entry_t e;
        e.tag = tag;
        e.v   = ev(st, rc);
        sb.push_back(e);
    endtask

    task automatic check_out();
        sb_entry_t e;
        e = sb.pop_front();
        vectors++;
        assert (obs === e.v) else begin
            miscompares++;
            $error("FAIL %s: observed %b required %b", e.tag, obs, e.v);
        end
    endtask

    task automatic frame_pulse();
        rx_frame_ok = 1'b1;
        step(1);
        rx_frame_ok = 1'b0;
    endtask

    initial begin
        res = 1'b1; enable = 1'b1; sfp_los = 1'b0; sfp_tx_flt = 1'b0;
        rx_frame_ok = 1'b0; retry_clr = 1'b0;
        step(2);
        expect_out("reset", 3'd0, 2'd0); check_out();
        res = 1'b0;

        // 1: power-up sequence, no peer
        expect_out("t1_init_dis_n", 3'd1, 2'd0); step(1); check_out();
        expect_out("t1_init_hold", 3'd1, 2'd0); step(19); check_out();
        expect_out("t1_wait_link", 3'd2, 2'd0); step(1); check_out();
        expect_out("t1_no_peer", 3'd2, 2'd0); step(120); check_out();

        // 2: link-up and receive timeout
        expect_out("t2_link_up", 3'd3, 2'd0); frame_pulse(); check_out();
        for (int i = 0; i < 3; i++) begin
            step(29);
            expect_out("t2_keepalive", 3'd3, 2'd0); frame_pulse(); check_out();
        end
        expect_out("t2_before_to", 3'd3, 2'd0); step(49); check_out();
        expect_out("t2_timeout", 3'd2, 2'd0); step(1); check_out();

        // 3: LOS drop and glitch rejection
        expect_out("t3_up", 3'd3, 2'd0); frame_pulse(); check_out();
        sfp_los = 1'b1;
        expect_out("t3_los_pending", 3'd3, 2'd0); step(5); check_out();
        expect_out("t3_los_down", 3'd2, 2'd0); step(1); check_out();
        sfp_los = 1'b0;
        step(8);
        expect_out("t3_up_again", 3'd3, 2'd0); frame_pulse(); check_out();
        sfp_los = 1'b1; step(2); sfp_los = 1'b0;
        expect_out("t3_glitch", 3'd3, 2'd0); step(10); check_out();

        // 4: fault recovery then lockout
        expect_out("t4_up", 3'd3, 2'd0); frame_pulse(); check_out();
        sfp_tx_flt = 1'b1;
        expect_out("t4_flt_sync", 3'd3, 2'd0); step(2); check_out();
        expect_out("t4_flt_dis1", 3'd4, 2'd1); step(1); check_out();
        expect_out("t4_flt_dis1_end", 3'd4, 2'd1); step(3); check_out();
        expect_out("t4_init1", 3'd1, 2'd1); step(1); check_out();
        expect_out("t4_init1_hold", 3'd1, 2'd1); step(19); check_out();
        expect_out("t4_flt_dis2", 3'd4, 2'd2); step(1); check_out();
        expect_out("t4_init2", 3'd1, 2'd2); step(4); check_out();
        expect_out("t4_init2_hold", 3'd1, 2'd2); step(19); check_out();
        expect_out("t4_lockout", 3'd5, 2'd2); step(1); check_out();

        // 5: lockout ignores enable, exits on retry_clr
        sfp_tx_flt = 1'b0;
        enable = 1'b0;
        expect_out("t5_en_low", 3'd5, 2'd2); step(1); check_out();
        enable = 1'b1;
        expect_out("t5_en_high", 3'd5, 2'd2); step(1); check_out();
        retry_clr = 1'b1;
        expect_out("t5_clr_off", 3'd0, 2'd0); step(1); check_out();
        retry_clr = 1'b0;
        expect_out("t5_reinit", 3'd1, 2'd0); step(1); check_out();

        // 6: asynchronous reset mid FLT_DIS and mid LINK_UP
        sfp_tx_flt = 1'b1;
        expect_out("t6_flt_dis", 3'd4, 2'd1); step(20); check_out();
        step(2);
        res = 1'b1; #1;
        expect_out("t6_rst_flt_dis", 3'd0, 2'd0); check_out();
        sfp_tx_flt = 1'b0;
        res = 1'b0;
        expect_out("t6_init", 3'd1, 2'd0); step(1); check_out();
        expect_out("t6_wait", 3'd2, 2'd0); step(20); check_out();
        expect_out("t6_up", 3'd3, 2'd0); frame_pulse(); check_out();
        step(3);
        res = 1'b1; #1;
        expect_out("t6_rst_link_up", 3'd0, 2'd0); check_out();
        expect_out("t6_rst_held", 3'd0, 2'd0); step(2); check_out();
        res = 1'b0;

        vectors++;
        assert (sb.size() === 0) else begin
            miscompares++;
            $error("FAIL sb_drain: observed %0d entries required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
